// File: rtl/dmem_loader_if.sv
// Host/CPU/memory signal bundle for dmem_loader: byte-stream command port,
// read-back port, CPU pass-through inputs and the data-memory side.
interface dmem_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              run;
  logic              cpu_c17;
  logic [ADDR_W-1:0] cpu_write_select;
  logic [DATA_W-1:0] cpu_inp;
  logic [ADDR_W-1:0] cpu_read_select;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              dm_run;
  logic              dm_c17;
  logic [ADDR_W-1:0] dm_write_select;
  logic [DATA_W-1:0] dm_inp;
  logic [ADDR_W-1:0] dm_read_select;
  logic [DATA_W-1:0] data_memory_output;

  // Environment side: host, CPU and the memory itself.
  modport master (
    output run, cpu_c17, cpu_write_select, cpu_inp, cpu_read_select,
    output rx_valid, rx_data, tx_ready, data_memory_output,
    input  rx_ready, tx_valid, tx_data,
    input  dm_run, dm_c17, dm_write_select, dm_inp, dm_read_select
  );

  modport slave (
    input  run, cpu_c17, cpu_write_select, cpu_inp, cpu_read_select,
    input  rx_valid, rx_data, tx_ready, data_memory_output,
    output rx_ready, tx_valid, tx_data,
    output dm_run, dm_c17, dm_write_select, dm_inp, dm_read_select
  );
endinterface

// File: rtl/dmem_loader.sv
// Host loader/readback for the 16x8 data memory: decodes a byte command stream
// into memory writes and reads while the CPU is halted, passes CPU signals through otherwise.
module dmem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  dmem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_PULSE, RD_ADDR, RD_SEND, BURST_CNT, BURST_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        txd_q, txd_d;
  logic              rx_fire;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    cnt_d               = cnt_q;
    data_d              = data_q;
    txd_d               = txd_q;
    bus.rx_ready        = 1'b0;
    bus.tx_valid        = 1'b0;
    bus.tx_data         = txd_q;
    bus.dm_run          = 1'b0;
    bus.dm_c17          = 1'b0;
    bus.dm_write_select = '0;
    bus.dm_inp          = '0;
    bus.dm_read_select  = addr_q;
    rx_fire             = 1'b0;

    if (bus.run) begin
      // CPU owns the memory; any partial loader command is dropped.
      bus.dm_run          = 1'b1;
      bus.dm_c17          = bus.cpu_c17;
      bus.dm_write_select = bus.cpu_write_select;
      bus.dm_inp          = bus.cpu_inp;
      bus.dm_read_select  = bus.cpu_read_select;
      state_d             = IDLE;
    end else begin
      unique case (state_q)
        IDLE, WR_DATA, BURST_CNT, BURST_DATA: bus.rx_ready = 1'b1;
        default:                              bus.rx_ready = 1'b0;
      endcase
      rx_fire = bus.rx_valid & bus.rx_ready;

      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            unique case (bus.rx_data[7:6])
              2'b00: begin
                addr_d  = bus.rx_data[ADDR_W-1:0];
                cnt_d   = '0;
                state_d = WR_DATA;
              end
              2'b01: begin
                addr_d  = bus.rx_data[ADDR_W-1:0];
                state_d = RD_ADDR;
              end
              2'b10: begin
                addr_d  = bus.rx_data[ADDR_W-1:0];
                state_d = BURST_CNT;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        WR_DATA, BURST_DATA: begin
          if (rx_fire) begin
            data_d  = bus.rx_data[DATA_W-1:0];
            state_d = WR_PULSE;
          end
        end
        BURST_CNT: begin
          if (rx_fire) begin
            cnt_d   = bus.rx_data[ADDR_W-1:0];
            state_d = BURST_DATA;
          end
        end
        WR_PULSE: begin
          bus.dm_run          = 1'b1;
          bus.dm_c17          = 1'b1;
          bus.dm_write_select = addr_q;
          bus.dm_inp          = data_q;
          // cnt_q holds words still owed after this one; address wraps naturally.
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = BURST_DATA;
          end else begin
            state_d = IDLE;
          end
        end
        RD_ADDR: begin
          txd_d   = 8'(bus.data_memory_output);
          state_d = RD_SEND;
        end
        RD_SEND: begin
          bus.tx_valid = 1'b1;
          if (bus.tx_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Randomized self-checking bench for dmem_loader with a behavioural memory
// and a command-level reference model of expected memory contents.
module tb_dmem_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dmem_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dmem_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem     [16];
  logic [7:0] exp_mem [16];
  int n_checks  = 0;
  int n_errors  = 0;
  int n_ld_wr   = 0;
  int exp_ld_wr = 0;

  // Behavioural 16x8 memory: untouched by reset_n, combinational read.
  always @(posedge clock) begin
    if (bus.dm_run && bus.dm_c17) begin
      mem[bus.dm_write_select] <= bus.dm_inp;
      if (!bus.run) n_ld_wr <= n_ld_wr + 1;
    end
  end
  assign bus.data_memory_output = mem[bus.dm_read_select];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.rx_ready) begin
      check_eq("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic check_pulse(input int a, input logic [7:0] d);
    check_eq("pulse_dm_run", 32'(bus.dm_run), 32'd1);
    check_eq("pulse_dm_c17", 32'(bus.dm_c17), 32'd1);
    check_eq("pulse_wsel", 32'(bus.dm_write_select), 32'(a));
    check_eq("pulse_inp", 32'(bus.dm_inp), 32'(d));
    check_eq("pulse_rx_ready", 32'(bus.rx_ready), 32'd0);
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    logic [1:0] junk = 2'($urandom);
    send_byte({2'b00, junk, 4'(a)});
    repeat ($urandom_range(0, 2)) @(negedge clock);
    send_byte(d);
    check_pulse(a, d);
    exp_mem[a] = d;
    exp_ld_wr++;
    @(negedge clock);
    check_eq("wr_single_pulse", 32'(bus.dm_c17), 32'd0);
  endtask

  task automatic do_burst(input int a, input int n);
    logic [7:0] d;
    send_byte({2'b10, 2'($urandom), 4'(a)});
    send_byte({4'($urandom), 4'(n - 1)});
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clock);
      d = 8'($urandom);
      send_byte(d);
      check_pulse((a + i) % 16, d);
      exp_mem[(a + i) % 16] = d;
      exp_ld_wr++;
    end
    @(negedge clock);
    check_eq("burst_end_c17", 32'(bus.dm_c17), 32'd0);
    check_eq("burst_end_idle", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic do_read(input int a, input int hold);
    send_byte({2'b01, 2'($urandom), 4'(a)});
    check_eq("rd_lat1_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("rd_rsel", 32'(bus.dm_read_select), 32'(a));
    check_eq("rd_lat1_rx_ready", 32'(bus.rx_ready), 32'd0);
    @(negedge clock);
    check_eq("rd_tx_valid", 32'(bus.tx_valid), 32'd1);
    check_eq("rd_tx_data", 32'(bus.tx_data), 32'(exp_mem[a]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("rd_hold_valid", 32'(bus.tx_valid), 32'd1);
      check_eq("rd_hold_data", 32'(bus.tx_data), 32'(exp_mem[a]));
      check_eq("rd_hold_rx_ready", 32'(bus.rx_ready), 32'd0);
    end
    bus.tx_ready = 1'b1;
    @(negedge clock);
    bus.tx_ready = 1'b0;
    check_eq("rd_done_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("rd_done_rx_ready", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic do_nop();
    send_byte({2'b11, 6'($urandom)});
    repeat (2) begin
      check_eq("nop_c17", 32'(bus.dm_c17), 32'd0);
      check_eq("nop_tx_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("nop_rx_ready", 32'(bus.rx_ready), 32'd1);
      @(negedge clock);
    end
  endtask

  initial begin
    logic [7:0] d;
    bus.run = 1'b0;
    bus.cpu_c17 = 1'b0;
    bus.cpu_write_select = '0;
    bus.cpu_inp = '0;
    bus.cpu_read_select = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clock);

    check_eq("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rst_dm_run", 32'(bus.dm_run), 32'd0);
    check_eq("rst_dm_c17", 32'(bus.dm_c17), 32'd0);
    check_eq("rst_wsel", 32'(bus.dm_write_select), 32'd0);
    check_eq("rst_inp", 32'(bus.dm_inp), 32'd0);
    check_eq("rst_rsel", 32'(bus.dm_read_select), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Preload every word so the model and memory agree.
    do_burst(0, 16);

    do_write(5, 8'hA7);
    do_read(5, 3);
    do_burst(14, 4);
    do_nop();

    // Run raised mid-command: partial write discarded, signals pass through.
    send_byte(8'h05);
    bus.run = 1'b1;
    bus.cpu_c17 = 1'($urandom);
    bus.cpu_write_select = 4'($urandom);
    bus.cpu_inp = 8'($urandom);
    bus.cpu_read_select = 4'($urandom);
    #1;
    check_eq("run_dm_run", 32'(bus.dm_run), 32'd1);
    check_eq("run_dm_c17", 32'(bus.dm_c17), 32'(bus.cpu_c17));
    check_eq("run_wsel", 32'(bus.dm_write_select), 32'(bus.cpu_write_select));
    check_eq("run_inp", 32'(bus.dm_inp), 32'(bus.cpu_inp));
    check_eq("run_rsel", 32'(bus.dm_read_select), 32'(bus.cpu_read_select));
    check_eq("run_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_eq("run_tx_valid", 32'(bus.tx_valid), 32'd0);
    if (bus.cpu_c17) exp_mem[bus.cpu_write_select] = bus.cpu_inp;
    @(negedge clock);
    bus.run = 1'b0;
    bus.cpu_c17 = 1'b0;
    #1;
    check_eq("unrun_rx_ready", 32'(bus.rx_ready), 32'd1);
    check_eq("unrun_c17", 32'(bus.dm_c17), 32'd0);
    @(negedge clock);
    send_byte(8'hA7);
    check_eq("a7_is_cmd_c17", 32'(bus.dm_c17), 32'd0);
    check_eq("a7_is_cmd_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h00);
    d = 8'($urandom);
    send_byte(d);
    check_pulse(7, d);
    exp_mem[7] = d;
    exp_ld_wr++;
    @(negedge clock);

    // Reset while a read-back byte is pending.
    send_byte(8'h4A);
    @(negedge clock);
    check_eq("rs_pre_tx_valid", 32'(bus.tx_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("rs_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_eq("rs_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rs_rx_ready", 32'(bus.rx_ready), 32'd1);
    check_eq("rs_rsel", 32'(bus.dm_read_select), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: do_write($urandom_range(0, 15), 8'($urandom));
        1: do_read($urandom_range(0, 15), $urandom_range(0, 3));
        2: do_burst($urandom_range(0, 15), $urandom_range(1, 16));
        default: do_nop();
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    for (int a = 0; a < 16; a++) begin
      check_eq("final_mem", 32'(mem[a]), 32'(exp_mem[a]));
      do_read(a, 0);
    end
    check_eq("loader_write_count", 32'(n_ld_wr), 32'(exp_ld_wr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
